// File: rtl/sweep_pkg.sv
// Shared definitions for the triangle-sweep sequencer.
//   sweep_state_t : sequencer FSM states
//   DEF_*         : default widths for counter/bounds, dwell field, sweep count
package sweep_pkg;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_DWELL_W = 4;
    localparam int DEF_CYC_W   = 8;

    typedef enum logic [2:0] {
        IDLE,
        UP,
        DWELL_TOP,
        DOWN,
        DWELL_BOT,
        DONE
    } sweep_state_t;

endpackage

// File: rtl/updown_counter_ld.sv
// WIDTH-bit up/down counter with synchronous load.
//   i_clk      : clock, rising edge
//   i_rst_n    : synchronous active-low reset, clears the count
//   i_load     : load i_load_val (priority over i_en)
//   i_load_val : value to load
//   i_en       : count enable
//   i_up       : 1 = increment, 0 = decrement
//   o_count    : current count
module updown_counter_ld
    import sweep_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    input  logic             i_up,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en) begin
            r_count <= i_up ? (r_count + 1'b1) : (r_count - 1'b1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/sweep_counter_ctrl.sv
// Triangle-sweep sequencer: ramps the owned counter lo->hi, dwells, hi->lo,
// dwells, for num_sweeps sweeps (0 = continuous).
//   clk         : clock, rising edge
//   reset       : synchronous active-low reset
//   start       : launch request, sampled only in IDLE
//   abort       : stop request, honoured in UP/DWELL_TOP/DOWN/DWELL_BOT
//   lo_bound    : sweep floor, latched on accepted start
//   hi_bound    : sweep ceiling, latched on accepted start
//   dwell       : hold cycles at each turning point, latched on accepted start
//   num_sweeps  : number of sweeps, 0 = continuous, latched on accepted start
//   count       : current counter value
//   dir_up      : high in UP and DWELL_TOP
//   busy        : high in any state other than IDLE
//   done        : one-cycle pulse in DONE
//   cfg_err     : one-cycle pulse after a start with lo_bound >= hi_bound
//   sweeps_done : completed sweeps since the last accepted start
module sweep_counter_ctrl
    import sweep_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DWELL_W = DEF_DWELL_W,
    parameter int CYC_W   = DEF_CYC_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH-1:0]   lo_bound,
    input  logic [WIDTH-1:0]   hi_bound,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [CYC_W-1:0]   num_sweeps,
    output logic [WIDTH-1:0]   count,
    output logic               dir_up,
    output logic               busy,
    output logic               done,
    output logic               cfg_err,
    output logic [CYC_W-1:0]   sweeps_done
);

    sweep_state_t       r_state;
    sweep_state_t       w_next;

    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_hi;
    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] r_dwell_cnt;
    logic [CYC_W-1:0]   r_num;
    logic [CYC_W-1:0]   r_sweeps;
    logic               r_cfg_err;

    logic [WIDTH-1:0]   w_count;
    logic [WIDTH-1:0]   w_cnt_inc;
    logic [WIDTH-1:0]   w_cnt_dec;
    logic [CYC_W-1:0]   w_sweeps_nxt;
    logic               w_accept;
    logic               w_reject;
    logic               w_load;
    logic               w_en;
    logic               w_up;
    logic               w_dwell_load;
    logic               w_dwell_dec;
    logic               w_sweep_inc;

    updown_counter_ld #(
        .WIDTH(WIDTH)
    ) u_cnt (
        .i_clk      (clk),
        .i_rst_n    (reset),
        .i_load     (w_load),
        .i_load_val (lo_bound),
        .i_en       (w_en),
        .i_up       (w_up),
        .o_count    (w_count)
    );

    always_comb begin
        w_accept     = (r_state == IDLE) && start && (lo_bound < hi_bound);
        w_reject     = (r_state == IDLE) && start && (lo_bound >= hi_bound);
        w_cnt_inc    = w_count + 1'b1;
        w_cnt_dec    = w_count - 1'b1;
        w_sweeps_nxt = r_sweeps + 1'b1;

        w_next       = r_state;
        w_load       = 1'b0;
        w_en         = 1'b0;
        w_up         = 1'b0;
        w_dwell_load = 1'b0;
        w_dwell_dec  = 1'b0;
        w_sweep_inc  = 1'b0;

        // Turning-point decisions look at count+/-1 so the counter lands on
        // the bound in the same cycle the next state is entered.
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_load = 1'b1;
                    w_next = UP;
                end
            end
            UP: begin
                if (abort) begin
                    w_next = IDLE;
                end else begin
                    w_en = 1'b1;
                    w_up = 1'b1;
                    if (w_cnt_inc == r_hi) begin
                        if (r_dwell != '0) begin
                            w_next       = DWELL_TOP;
                            w_dwell_load = 1'b1;
                        end else begin
                            w_next = DOWN;
                        end
                    end
                end
            end
            DWELL_TOP: begin
                if (abort) begin
                    w_next = IDLE;
                end else begin
                    w_dwell_dec = 1'b1;
                    if (r_dwell_cnt == DWELL_W'(1)) begin
                        w_next = DOWN;
                    end
                end
            end
            DOWN: begin
                if (abort) begin
                    w_next = IDLE;
                end else begin
                    w_en = 1'b1;
                    if (w_cnt_dec == r_lo) begin
                        w_sweep_inc = 1'b1;
                        if ((r_num != '0) && (w_sweeps_nxt == r_num)) begin
                            w_next = DONE;
                        end else if (r_dwell != '0) begin
                            w_next       = DWELL_BOT;
                            w_dwell_load = 1'b1;
                        end else begin
                            w_next = UP;
                        end
                    end
                end
            end
            DWELL_BOT: begin
                if (abort) begin
                    w_next = IDLE;
                end else begin
                    w_dwell_dec = 1'b1;
                    if (r_dwell_cnt == DWELL_W'(1)) begin
                        w_next = UP;
                    end
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_lo        <= '0;
            r_hi        <= '0;
            r_dwell     <= '0;
            r_num       <= '0;
            r_dwell_cnt <= '0;
            r_sweeps    <= '0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cfg_err <= w_reject;
            if (w_accept) begin
                r_lo     <= lo_bound;
                r_hi     <= hi_bound;
                r_dwell  <= dwell;
                r_num    <= num_sweeps;
                r_sweeps <= '0;
            end else if (w_sweep_inc) begin
                r_sweeps <= w_sweeps_nxt;
            end
            if (w_dwell_load) begin
                r_dwell_cnt <= r_dwell;
            end else if (w_dwell_dec) begin
                r_dwell_cnt <= r_dwell_cnt - 1'b1;
            end
        end
    end

    assign count       = w_count;
    assign dir_up      = (r_state == UP) || (r_state == DWELL_TOP);
    assign busy        = (r_state != IDLE);
    assign done        = (r_state == DONE);
    assign cfg_err     = r_cfg_err;
    assign sweeps_done = r_sweeps;

endmodule

// File: tb/tb_sweep_counter_ctrl.sv
// Directed bench for sweep_counter_ctrl. Each stimulus cycle pushes the
// hand-computed outputs expected after the next rising edge; a monitor pops
// one entry per falling edge and compares it with the DUT outputs.
module tb_sweep_counter_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic [3:0] lo_bound;
    logic [3:0] hi_bound;
    logic [3:0] dwell;
    logic [7:0] num_sweeps;
    logic [3:0] count;
    logic       dir_up;
    logic       busy;
    logic       done;
    logic       cfg_err;
    logic [7:0] sweeps_done;

    typedef struct {
        logic [3:0] cnt;
        logic       busy;
        logic       done;
        logic       dir;
        logic       cerr;
        logic [7:0] sw;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [3:0] c_lo, c_hi, c_dw;
    logic [7:0] c_ns;

    logic [3:0] seq_c [6] = '{4'd1, 4'd2, 4'd3, 4'd2, 4'd1, 4'd0};
    logic       seq_d [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    sweep_counter_ctrl #(
        .WIDTH   (4),
        .DWELL_W (4),
        .CYC_W   (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .lo_bound    (lo_bound),
        .hi_bound    (hi_bound),
        .dwell       (dwell),
        .num_sweeps  (num_sweeps),
        .count       (count),
        .dir_up      (dir_up),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err),
        .sweeps_done (sweeps_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cfg(input logic [3:0] lo, input logic [3:0] hi,
                       input logic [3:0] dw, input logic [7:0] ns);
        c_lo = lo;
        c_hi = hi;
        c_dw = dw;
        c_ns = ns;
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic cy(input logic rst, input logic st, input logic ab,
                      input logic [3:0] e_cnt, input logic e_busy,
                      input logic e_done, input logic e_dir,
                      input logic e_cerr, input logic [7:0] e_sw,
                      input string tag);
        exp_t e;
        @(negedge clk);
        #1;
        reset      = rst;
        start      = st;
        abort      = ab;
        lo_bound   = c_lo;
        hi_bound   = c_hi;
        dwell      = c_dw;
        num_sweeps = c_ns;
        e.cnt  = e_cnt;
        e.busy = e_busy;
        e.done = e_done;
        e.dir  = e_dir;
        e.cerr = e_cerr;
        e.sw   = e_sw;
        e.tag  = tag;
        q.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_tests++;
                if (count !== e.cnt || busy !== e.busy || done !== e.done ||
                    dir_up !== e.dir || cfg_err !== e.cerr || sweeps_done !== e.sw) begin
                    n_fail++;
                    $display("FAIL %s: got cnt=%0d busy=%0b done=%0b dir=%0b cerr=%0b sw=%0d, want cnt=%0d busy=%0b done=%0b dir=%0b cerr=%0b sw=%0d",
                             e.tag, count, busy, done, dir_up, cfg_err, sweeps_done,
                             e.cnt, e.busy, e.done, e.dir, e.cerr, e.sw);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        lo_bound = '0; hi_bound = '0; dwell = '0; num_sweeps = '0;
        cfg(4'd0, 4'd0, 4'd0, 8'd0);

        cy(0, 0, 0, 4'd0, 0, 0, 0, 0, 8'd0, "reset0");
        cy(0, 0, 0, 4'd0, 0, 0, 0, 0, 8'd0, "reset1");

        // Single sweep with dwell 1
        cfg(4'd2, 4'd5, 4'd1, 8'd1);
        cy(1, 1, 0, 4'd2, 1, 0, 1, 0, 8'd0, "s_start");
        cy(1, 0, 0, 4'd3, 1, 0, 1, 0, 8'd0, "s_up3");
        cy(1, 0, 0, 4'd4, 1, 0, 1, 0, 8'd0, "s_up4");
        cy(1, 0, 0, 4'd5, 1, 0, 1, 0, 8'd0, "s_dtop");
        cy(1, 0, 0, 4'd5, 1, 0, 0, 0, 8'd0, "s_dn5");
        cy(1, 0, 0, 4'd4, 1, 0, 0, 0, 8'd0, "s_dn4");
        cy(1, 0, 0, 4'd3, 1, 0, 0, 0, 8'd0, "s_dn3");
        cy(1, 0, 0, 4'd2, 1, 1, 0, 0, 8'd1, "s_done");
        cy(1, 0, 0, 4'd2, 0, 0, 0, 0, 8'd1, "s_idle");

        // Rejected configurations
        cfg(4'd7, 4'd7, 4'd0, 8'd0);
        cy(1, 1, 0, 4'd2, 0, 0, 0, 1, 8'd1, "bad_eq");
        cy(1, 0, 0, 4'd2, 0, 0, 0, 0, 8'd1, "bad_eq_clr");
        cfg(4'd8, 4'd3, 4'd0, 8'd0);
        cy(1, 1, 0, 4'd2, 0, 0, 0, 1, 8'd1, "bad_gt");
        cy(1, 0, 0, 4'd2, 0, 0, 0, 0, 8'd1, "bad_gt_clr");

        // Continuous, no dwell: three sweeps then abort
        cfg(4'd0, 4'd3, 4'd0, 8'd0);
        cy(1, 1, 0, 4'd0, 1, 0, 1, 0, 8'd0, "c_start");
        for (int unsigned k = 0; k < 3; k++) begin
            for (int unsigned i = 0; i < 6; i++) begin
                cy(1, 0, 0, seq_c[i], 1, 0, seq_d[i], 0,
                   8'(k + ((i == 5) ? 1 : 0)), "c_run");
            end
        end
        cy(1, 0, 1, 4'd0, 0, 0, 0, 0, 8'd3, "c_abort");

        // Abort mid-UP, then immediate restart with hi = lo+1, two sweeps
        cfg(4'd1, 4'd9, 4'd2, 8'd0);
        cy(1, 1, 0, 4'd1, 1, 0, 1, 0, 8'd0, "a_start");
        cy(1, 0, 0, 4'd2, 1, 0, 1, 0, 8'd0, "a_up2");
        cy(1, 0, 0, 4'd3, 1, 0, 1, 0, 8'd0, "a_up3");
        cy(1, 0, 0, 4'd4, 1, 0, 1, 0, 8'd0, "a_up4");
        cy(1, 0, 1, 4'd4, 0, 0, 0, 0, 8'd0, "a_freeze");
        cfg(4'd3, 4'd4, 4'd0, 8'd2);
        cy(1, 1, 0, 4'd3, 1, 0, 1, 0, 8'd0, "a_restart");
        cy(1, 0, 0, 4'd4, 1, 0, 0, 0, 8'd0, "a_dn");
        cy(1, 0, 0, 4'd3, 1, 0, 1, 0, 8'd1, "a_up");
        cy(1, 0, 0, 4'd4, 1, 0, 0, 0, 8'd1, "a_dn2");
        cy(1, 0, 0, 4'd3, 1, 1, 0, 0, 8'd2, "a_done");
        cy(1, 0, 1, 4'd3, 0, 0, 0, 0, 8'd2, "done_abort");

        // Start while busy with changed config is ignored
        cfg(4'd2, 4'd4, 4'd2, 8'd1);
        cy(1, 1, 0, 4'd2, 1, 0, 1, 0, 8'd0, "b_start");
        cfg(4'd0, 4'd9, 4'd0, 8'd0);
        cy(1, 1, 0, 4'd3, 1, 0, 1, 0, 8'd0, "b_ignore");
        cy(1, 0, 0, 4'd4, 1, 0, 1, 0, 8'd0, "b_dtop1");
        cy(1, 0, 0, 4'd4, 1, 0, 1, 0, 8'd0, "b_dtop2");
        cy(1, 1, 0, 4'd4, 1, 0, 0, 0, 8'd0, "b_dn4");
        cy(1, 0, 0, 4'd3, 1, 0, 0, 0, 8'd0, "b_dn3");
        cy(1, 0, 0, 4'd2, 1, 1, 0, 0, 8'd1, "b_done");
        cy(1, 0, 0, 4'd2, 0, 0, 0, 0, 8'd1, "b_idle");

        // Dwell at both ends, then reset during DWELL_TOP with start held
        cfg(4'd1, 4'd2, 4'd1, 8'd0);
        cy(1, 1, 0, 4'd1, 1, 0, 1, 0, 8'd0, "r_start");
        cy(1, 0, 0, 4'd2, 1, 0, 1, 0, 8'd0, "r_dtop");
        cy(1, 0, 0, 4'd2, 1, 0, 0, 0, 8'd0, "r_dn");
        cy(1, 0, 0, 4'd1, 1, 0, 0, 0, 8'd1, "r_dbot");
        cy(1, 0, 0, 4'd1, 1, 0, 1, 0, 8'd1, "r_up");
        cy(1, 0, 0, 4'd2, 1, 0, 1, 0, 8'd1, "r_dtop2");
        cy(0, 1, 0, 4'd0, 0, 0, 0, 0, 8'd0, "rst_mid");
        cy(0, 1, 0, 4'd0, 0, 0, 0, 0, 8'd0, "rst_hold");
        cy(1, 0, 0, 4'd0, 0, 0, 0, 0, 8'd0, "post_rst");

        // Fresh start after reset
        cfg(4'd5, 4'd6, 4'd0, 8'd1);
        cy(1, 1, 0, 4'd5, 1, 0, 1, 0, 8'd0, "f_start");
        cy(1, 0, 0, 4'd6, 1, 0, 0, 0, 8'd0, "f_dn");
        cy(1, 0, 0, 4'd5, 1, 1, 0, 0, 8'd1, "f_done");
        cy(1, 0, 0, 4'd5, 0, 0, 0, 0, 8'd1, "f_idle");

        @(negedge clk);
        @(negedge clk);
        #1;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
